// File: rtl/s_p_pkg.sv
// s_p_pkg: shared constants and state enums for the s_p
// serial-to-parallel converter.
package s_p_pkg;
  localparam int DATA_W = 34;
  localparam int LANES  = 4;
  localparam int DEPTH  = LANES * LANES;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_st_e;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_st_e;
endpackage

// File: rtl/s_p_if.sv
// s_p_if: sample stream in, parallel beat stream out.
// The master drives samples and stall; the slave returns beats.
interface s_p_if #(
  parameter int DATA_W = s_p_pkg::DATA_W,
  parameter int LANES  = s_p_pkg::LANES
);
  logic [DATA_W-1:0]       data_in;
  logic                    valid_in;
  logic                    hold_in;
  logic [LANES*DATA_W-1:0] data_out;
  logic                    p_s_flag_out;
  logic                    frame_done;
  logic                    overflow;

  modport master (
    output data_in, valid_in, hold_in,
    input  data_out, p_s_flag_out,
    input  frame_done, overflow
  );

  modport slave (
    input  data_in, valid_in, hold_in,
    output data_out, p_s_flag_out,
    output frame_done, overflow
  );
endinterface

// File: rtl/s_p_bank.sv
// s_p_bank: one LANES*LANES sample register bank with a write
// port and a LANES-wide beat read port (row-major or transposed).
module s_p_bank #(
  parameter  int DATA_W = s_p_pkg::DATA_W,
  parameter  int LANES  = s_p_pkg::LANES,
  localparam int DEPTH  = LANES * LANES,
  localparam int IW     = $clog2(DEPTH),
  localparam int BW     = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [IW-1:0]           widx_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic [BW-1:0]           beat_i,
  input  logic                    tr_i,
  output logic [LANES*DATA_W-1:0] beat_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wdata_i;
  end

  // transposed: lane j = sample b+LANES*j, else LANES*b+j
  always_comb begin
    beat_o = '0;
    for (int j = 0; j < LANES; j++) begin
      if (tr_i)
        beat_o[j*DATA_W +: DATA_W] =
          mem_q[IW'(int'(beat_i) + LANES * j)];
      else
        beat_o[j*DATA_W +: DATA_W] =
          mem_q[IW'(LANES * int'(beat_i) + j)];
    end
  end
endmodule

// File: rtl/s_p.sv
// s_p: ping-pong serial-to-parallel converter, bursts of LANES beats.
// Define S_P_TRANSPOSE_EN for column-to-row transposed beats.
module s_p #(
  parameter int DATA_W = s_p_pkg::DATA_W,
  parameter int LANES  = s_p_pkg::LANES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    valid_in,
  input  logic                    hold_in,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic                    p_s_flag_out,
  output logic                    frame_done,
  output logic                    overflow
);
  import s_p_pkg::*;

  localparam int FRAME = LANES * LANES;
  localparam int IW    = $clog2(FRAME);
  localparam int BW    = $clog2(LANES);
  localparam int OW    = LANES * DATA_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME - 1);
  localparam logic [BW-1:0] LAST_B   = BW'(LANES - 1);

`ifdef S_P_TRANSPOSE_EN
  localparam logic TRANSPOSE = 1'b1;
`else
  localparam logic TRANSPOSE = 1'b0;
`endif

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  drain_st_e       state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [BW-1:0]   b_q, b_d;
  logic [OW-1:0]   dout_q, dout_d;
  logic            flag_q, flag_d;
  logic            fd_q, fd_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic [1:0]      we;
  logic [BW-1:0]   rd_beat;
  logic            rd_sel;
  logic [OW-1:0]   beat0, beat1, beat_mux;

  assign accept = valid_in && (bank_q[wr_bank_q] != FULL);
  assign we     = {accept && wr_bank_q, accept && !wr_bank_q};

  // beat to load next edge: next beat, or beat 0 of the other bank
  assign rd_beat = (state_q == DRAIN && b_q != LAST_B) ?
                   b_q + 1'b1 : '0;
  assign rd_sel  = (state_q == DRAIN && b_q == LAST_B) ?
                   !rd_bank_q : rd_bank_q;
  assign beat_mux = rd_sel ? beat1 : beat0;

  s_p_bank #(.DATA_W(DATA_W), .LANES(LANES)) u_bank0 (
    .clk     (clk),
    .we_i    (we[0]),
    .widx_i  (wr_idx_q),
    .wdata_i (data_in),
    .beat_i  (rd_beat),
    .tr_i    (TRANSPOSE),
    .beat_o  (beat0)
  );

  s_p_bank #(.DATA_W(DATA_W), .LANES(LANES)) u_bank1 (
    .clk     (clk),
    .we_i    (we[1]),
    .widx_i  (wr_idx_q),
    .wdata_i (data_in),
    .beat_i  (rd_beat),
    .tr_i    (TRANSPOSE),
    .beat_o  (beat1)
  );

  always_comb begin
    bank_d    = bank_q;
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    b_d       = b_q;
    dout_d    = dout_q;
    flag_d    = flag_q;
    fd_d      = fd_q;
    ovf_d     = ovf_q;

    if (accept) begin
      if (wr_idx_q == LAST_IDX) begin
        bank_d[wr_bank_q] = FULL;
        wr_idx_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = FILLING;
        wr_idx_d          = wr_idx_q + 1'b1;
      end
    end else if (valid_in) begin
      ovf_d = 1'b1;
    end

    // frames complete in bank order, so rd_bank is always the oldest
    unique case (state_q)
      IDLE: begin
        if (bank_q[rd_bank_q] == FULL) begin
          state_d = DRAIN;
          b_d     = '0;
          dout_d  = beat_mux;
          flag_d  = 1'b0;
          fd_d    = 1'b0;
        end
      end
      DRAIN: begin
        if (!hold_in) begin
          if (b_q != LAST_B) begin
            b_d    = rd_beat;
            dout_d = beat_mux;
            fd_d   = (rd_beat == LAST_B);
          end else begin
            bank_d[rd_bank_q] = EMPTY;
            rd_bank_d         = !rd_bank_q;
            b_d               = '0;
            fd_d              = 1'b0;
            if (bank_q[!rd_bank_q] == FULL) begin
              dout_d = beat_mux;
            end else begin
              state_d = IDLE;
              flag_d  = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      state_q   <= IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      flag_q    <= 1'b1;
      fd_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      flag_q    <= flag_d;
      fd_q      <= fd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign data_out     = dout_q;
  assign p_s_flag_out = flag_q;
  assign frame_done   = fd_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_s_p.sv
// tb_s_p: bench for s_p against a frame-queue reference model.
// Works with or without S_P_TRANSPOSE_EN; the model follows the macro.
module tb_s_p;
  localparam int DW = 34;
  localparam int L  = 4;
  localparam int N  = L * L;
  localparam int OW = L * DW;
`ifdef S_P_TRANSPOSE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  s_p_if #(.DATA_W(DW), .LANES(L)) sif ();

  s_p #(.DATA_W(DW), .LANES(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (sif.data_in),
    .valid_in     (sif.valid_in),
    .hold_in      (sif.hold_in),
    .data_out     (sif.data_out),
    .p_s_flag_out (sif.p_s_flag_out),
    .frame_done   (sif.frame_done),
    .overflow     (sif.overflow)
  );

  always #5 clk = ~clk;

  // reference model: queue of complete frames plus a partial frame
  logic [DW-1:0] cur [$];
  logic [DW-1:0] pend [$];
  int            m_beat = -1;
  logic [OW-1:0] m_do   = '0;
  logic          m_flag = 1'b1;
  logic          m_fd   = 1'b0;
  logic          m_ovf  = 1'b0;

  function automatic logic [OW-1:0] beat_of(input int b);
    logic [OW-1:0] r = '0;
    for (int j = 0; j < L; j++)
      r[j*DW +: DW] = pend[TR ? b + L*j : L*b + j];
    return r;
  endfunction

  always @(posedge clk) begin : model
    int np;
    if (rst) begin
      cur.delete();
      pend.delete();
      m_beat = -1;
      m_do   = '0;
      m_flag = 1'b1;
      m_fd   = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      np = pend.size() / N;
      if (m_beat < 0) begin
        if (np > 0) begin
          m_beat = 0;
          m_do   = beat_of(0);
          m_flag = 1'b0;
          m_fd   = 1'b0;
        end
      end else if (!sif.hold_in) begin
        if (m_beat < L - 1) begin
          m_beat++;
          m_do = beat_of(m_beat);
          m_fd = (m_beat == L - 1);
        end else begin
          repeat (N) void'(pend.pop_front());
          m_fd = 1'b0;
          if (np > 1) begin
            m_beat = 0;
            m_do   = beat_of(0);
          end else begin
            m_beat = -1;
            m_flag = 1'b1;
          end
        end
      end
      if (sif.valid_in) begin
        if (np == 2) begin
          m_ovf = 1'b1;
        end else begin
          cur.push_back(sif.data_in);
          if (cur.size() == N) begin
            foreach (cur[i]) pend.push_back(cur[i]);
            cur.delete();
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic tick(input logic r, input logic v,
                      input logic [DW-1:0] d, input logic h);
    rst          = r;
    sif.valid_in = v;
    sif.data_in  = d;
    sif.hold_in  = h;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, rnd(), 1'b1);
    tick(1'b1, 1'b1, rnd(), 1'b0);
    checks++;
    if ({sif.data_out, sif.p_s_flag_out, sif.frame_done,
         sif.overflow} !== {{OW{1'b0}}, 3'b100}) begin
      errors++;
      $display("FAIL reset: got %h/%b%b%b req 0/100", sif.data_out,
               sif.p_s_flag_out, sif.frame_done, sif.overflow);
    end
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, 1'b0, rnd(), 1'b0);
      checks++;
      if (sif.p_s_flag_out !== 1'b1 || sif.overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c=%0d: flag=%b ovf=%b req 1/0",
                 c, sif.p_s_flag_out, sif.overflow);
      end
    end
  endtask

  task automatic test_continuous();
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < N + 8; c++) begin
      tick(1'b0, c < N, DW'(c), 1'b0);
      checks++;
      if ({sif.data_out, sif.p_s_flag_out, sif.frame_done,
           sif.overflow} !== {m_do, m_flag, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL cont c=%0d: got %h/%b%b%b req %h/%b%b%b", c,
                 sif.data_out, sif.p_s_flag_out, sif.frame_done,
                 sif.overflow, m_do, m_flag, m_fd, m_ovf);
      end
      if (c == N) begin
        checks++;
        if (sif.data_out[3*DW +: DW] !== DW'(TR ? 12 : 3) ||
            sif.data_out[0 +: DW] !== DW'(0) ||
            sif.p_s_flag_out !== 1'b0) begin
          errors++;
          $display("FAIL cont_beat0: lane3=%0d lane0=%0d flag=%b",
                   sif.data_out[3*DW +: DW], sif.data_out[0 +: DW],
                   sif.p_s_flag_out);
        end
      end
      if (c == N + 3) begin
        checks++;
        if (sif.frame_done !== 1'b1 ||
            sif.data_out[3*DW +: DW] !== DW'(15)) begin
          errors++;
          $display("FAIL cont_beat3: fd=%b lane3=%0d req 1/15",
                   sif.frame_done, sif.data_out[3*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int fds = 0;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 3*N + 16; c++) begin
      tick(1'b0, c < 3*N, rnd(), 1'b0);
      if (sif.frame_done === 1'b1) fds++;
      checks++;
      if ({sif.data_out, sif.p_s_flag_out, sif.frame_done,
           sif.overflow} !== {m_do, m_flag, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL b2b c=%0d: got %h/%b%b%b req %h/%b%b%b", c,
                 sif.data_out, sif.p_s_flag_out, sif.frame_done,
                 sif.overflow, m_do, m_flag, m_fd, m_ovf);
      end
    end
    checks++;
    if (fds !== 3 || sif.overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bursts: bursts=%0d ovf=%b req 3/0",
               fds, sif.overflow);
    end
  endtask

  task automatic test_stall();
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 70; c++) begin
      tick(1'b0, c < 40, rnd(), c >= 18 && c < 48);
      checks++;
      if ({sif.data_out, sif.p_s_flag_out, sif.frame_done,
           sif.overflow} !== {m_do, m_flag, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL stall c=%0d: got %h/%b%b%b req %h/%b%b%b", c,
                 sif.data_out, sif.p_s_flag_out, sif.frame_done,
                 sif.overflow, m_do, m_flag, m_fd, m_ovf);
      end
    end
    checks++;
    if (sif.overflow !== 1'b1) begin
      errors++;
      $display("FAIL stall_ovf: got %b req 1", sif.overflow);
    end
  endtask

  task automatic test_midreset();
    logic [DW-1:0] a [N];
    int first = -1;
    logic [DW-1:0] lane0 = '0;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b1, rnd(), 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (sif.p_s_flag_out !== 1'b1 || sif.data_out !== '0) begin
      errors++;
      $display("FAIL midrst: flag=%b dout=%h req 1/0",
               sif.p_s_flag_out, sif.data_out);
    end
    foreach (a[i]) a[i] = rnd();
    for (int c = 0; c < N + 10; c++) begin
      tick(1'b0, c < N, c < N ? a[c] : '0, 1'b0);
      if (first < 0 && sif.p_s_flag_out === 1'b0) begin
        first = c;
        lane0 = sif.data_out[0 +: DW];
      end
      checks++;
      if ({sif.data_out, sif.p_s_flag_out, sif.frame_done,
           sif.overflow} !== {m_do, m_flag, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL midrst c=%0d: got %h/%b%b%b req %h/%b%b%b", c,
                 sif.data_out, sif.p_s_flag_out, sif.frame_done,
                 sif.overflow, m_do, m_flag, m_fd, m_ovf);
      end
    end
    checks++;
    if (first !== N || lane0 !== a[0]) begin
      errors++;
      $display("FAIL midrst_burst: start=%0d lane0=%h req %0d/%h",
               first, lane0, N, a[0]);
    end
  endtask

  task automatic test_sparse();
    int first = -1;
    int lows = 0;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 2*N + 10; c++) begin
      tick(1'b0, c < 2*N && (c % 2 == 0), rnd(), 1'b0);
      if (sif.p_s_flag_out === 1'b0) begin
        lows++;
        if (first < 0) first = c;
      end
      checks++;
      if ({sif.data_out, sif.p_s_flag_out, sif.frame_done,
           sif.overflow} !== {m_do, m_flag, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL sparse c=%0d: got %h/%b%b%b req %h/%b%b%b", c,
                 sif.data_out, sif.p_s_flag_out, sif.frame_done,
                 sif.overflow, m_do, m_flag, m_fd, m_ovf);
      end
    end
    checks++;
    if (first !== 2*N - 1 || lows !== L) begin
      errors++;
      $display("FAIL sparse_burst: start=%0d beats=%0d req %0d/%0d",
               first, lows, 2*N - 1, L);
    end
  endtask

  task automatic test_random();
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           rnd(), $urandom_range(0, 5) == 0);
      checks++;
      if ({sif.data_out, sif.p_s_flag_out, sif.frame_done,
           sif.overflow} !== {m_do, m_flag, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL random c=%0d: got %h/%b%b%b req %h/%b%b%b", c,
                 sif.data_out, sif.p_s_flag_out, sif.frame_done,
                 sif.overflow, m_do, m_flag, m_fd, m_ovf);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    sif.valid_in = 1'b0;
    sif.data_in  = '0;
    sif.hold_in  = 1'b0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_back_to_back();
    test_stall();
    test_midreset();
    test_sparse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
